// File: rtl/spi_master_pkg.sv
// Shared types for the parametrised SPI master.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } stateT;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } modeT;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: one tick every CLK_DIV cycles while shifting. The first
// tick comes from kick, on the same edge that enters SHIFT.
module spi_clk_gen #(
  parameter int CLK_DIV    = 2,
  parameter bit RESET_CPOL = 1'b1
) (
  input  logic Clk,
  input  logic reset,
  input  logic enable,    // FSM is in SHIFT
  input  logic kick,      // FSM enters SHIFT on this edge
  input  logic stop,      // all edges done; the next tick ends SHIFT
  input  logic idleLvl,   // SCLK level to rest at outside SHIFT
  output logic tick,
  output logic leadEdge,
  output logic trailEdge,
  output logic sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] divCnt;
  logic          trailNext;  // 0: next SCLK edge is leading, 1: trailing

  assign tick      = kick | (enable & (divCnt == DIV_LAST));
  assign leadEdge  = tick & ~stop & ~trailNext;
  assign trailEdge = tick & ~stop & trailNext;

  // Divider count, edge phase and the SCLK level itself.
  always_ff @(posedge Clk) begin
    if (reset) begin
      divCnt    <= '0;
      trailNext <= 1'b0;
      sclk      <= RESET_CPOL;
    end else if (!enable) begin
      divCnt    <= '0;
      trailNext <= kick;
      sclk      <= kick ? ~idleLvl : idleLvl;
    end else begin
      divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + CW'(1);
      if (leadEdge || trailEdge) begin
        trailNext <= ~trailNext;
        sclk      <= ~sclk;
      end
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master: MSB-first TX on SDI, SDO captured into
// SerialDataIn, all four modes, NUM_CS one-hot-low chip selects.
module spi_master_param
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CS     = 4,
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 1,
  parameter int CS_HOLD    = 1,
  parameter bit RESET_CPOL = 1'b1
) (
  input  logic                                        Clk,
  input  logic                                        reset,
  input  logic [DATA_WIDTH-1:0]                       SerialData,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] CsSelect,
  input  logic                                        Cpol,
  input  logic                                        Cpha,
  input  logic                                        DataoutStart,
  output logic                                        Busy,
  output logic                                        DataoutDone,
  output logic                                        SelError,
  output logic [DATA_WIDTH-1:0]                       SerialDataIn,
  output logic                                        SCLK,
  output logic                                        SDI,
  input  logic                                        SDO,
  output logic [NUM_CS-1:0]                           nCS
);

  localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int BW    = $clog2(DATA_WIDTH + 1);
  localparam int WMAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PCW   = (WMAX > 1) ? $clog2(WMAX + 1) : 1;

  stateT                 state, stateNext;
  modeT                  mode;
  logic [PCW-1:0]        waitCnt;
  logic [BW-1:0]         bitCnt;
  logic [DATA_WIDTH-1:0] txShift, rxShift;
  logic                  accept, reject, kick, finish, csValid;
  logic                  tick, leadEdge, trailEdge, idleLvl;

  assign csValid = ({1'b0, CsSelect} < (CSW + 1)'(NUM_CS));
  // New Cpol takes effect on the accept edge so SCLK idles correctly in SETUP.
  assign idleLvl = accept ? Cpol : mode.cpol;

  spi_clk_gen #(.CLK_DIV(CLK_DIV), .RESET_CPOL(RESET_CPOL)) uClkGen (
    .Clk       (Clk),
    .reset     (reset),
    .enable    (state == SHIFT),
    .kick      (kick),
    .stop      (bitCnt == BW'(DATA_WIDTH)),
    .idleLvl   (idleLvl),
    .tick      (tick),
    .leadEdge  (leadEdge),
    .trailEdge (trailEdge),
    .sclk      (SCLK)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next state and single-cycle control strobes. DONE also accepts a start
  // so back-to-back words see exactly one cycle of nCS high.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    reject    = 1'b0;
    kick      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        stateNext = IDLE;
        if (DataoutStart && csValid) begin
          accept    = 1'b1;
          stateNext = SETUP;
        end else if (DataoutStart) begin
          reject = 1'b1;
        end
      end
      SETUP: if (waitCnt == PCW'(CS_SETUP - 1)) begin
        kick      = 1'b1;
        stateNext = SHIFT;
      end
      SHIFT: if (tick && bitCnt == BW'(DATA_WIDTH)) stateNext = HOLD;
      HOLD: if (waitCnt == PCW'(CS_HOLD - 1)) begin
        finish    = 1'b1;
        stateNext = DONE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: selects, shift registers, SDI and status outputs.
  always_ff @(posedge Clk) begin
    if (reset) begin
      mode         <= '{cpol: RESET_CPOL, cpha: 1'b0};
      waitCnt      <= '0;
      bitCnt       <= '0;
      txShift      <= '0;
      rxShift      <= '0;
      Busy         <= 1'b0;
      DataoutDone  <= 1'b0;
      SelError     <= 1'b0;
      SerialDataIn <= '0;
      SDI          <= 1'b0;
      nCS          <= '1;
    end else begin
      DataoutDone <= finish;
      SelError    <= reject;
      waitCnt     <= (stateNext == state && (state == SETUP || state == HOLD))
                     ? waitCnt + PCW'(1) : '0;
      if (accept) begin
        mode    <= '{cpol: Cpol, cpha: Cpha};
        txShift <= SerialData;
        rxShift <= '0;
        bitCnt  <= '0;
        SDI     <= Cpha ? 1'b0 : SerialData[DATA_WIDTH-1];
        nCS     <= ~(NUM_CS'(1) << CsSelect);
        Busy    <= 1'b1;
      end else if (leadEdge) begin
        if (mode.cpha) begin
          SDI     <= txShift[DATA_WIDTH-1];
          txShift <= txShift << 1;
        end else begin
          rxShift <= {rxShift[DATA_WIDTH-2:0], SDO};
        end
      end else if (trailEdge) begin
        bitCnt <= bitCnt + BW'(1);
        if (mode.cpha) begin
          rxShift <= {rxShift[DATA_WIDTH-2:0], SDO};
        end else if (bitCnt != BW'(DATA_WIDTH - 1)) begin
          SDI     <= txShift[DATA_WIDTH-2];
          txShift <= txShift << 1;
        end
      end else if (finish) begin
        nCS          <= '1;
        SDI          <= 1'b0;
        Busy         <= 1'b0;
        SerialDataIn <= rxShift;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: three parameterisations share Clk/reset and a
// common stimulus bus; `sel` routes start and picks which outputs are watched.
module tb_spi_master_param;

  logic        Clk = 1'b0;
  logic        reset;
  logic [23:0] sdata;
  logic [1:0]  csSel;
  logic        cpol, cpha, sdo, start;
  int          sel;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 Clk = ~Clk;

  logic busyA, doneA, selErrA, sclkA, sdiA; logic [15:0] rdA; logic [3:0] ncsA;
  logic busyB, doneB, selErrB, sclkB, sdiB; logic [23:0] rdB; logic [2:0] ncsB;
  logic busyC, doneC, selErrC, sclkC, sdiC; logic [23:0] rdC; logic [2:0] ncsC;

  spi_master_param dutA (
    .Clk(Clk), .reset(reset), .SerialData(sdata[15:0]), .CsSelect(csSel),
    .Cpol(cpol), .Cpha(cpha), .DataoutStart(start && sel == 0), .Busy(busyA),
    .DataoutDone(doneA), .SelError(selErrA), .SerialDataIn(rdA), .SCLK(sclkA),
    .SDI(sdiA), .SDO(sdo), .nCS(ncsA));

  spi_master_param #(.DATA_WIDTH(24), .NUM_CS(3), .CLK_DIV(1)) dutB (
    .Clk(Clk), .reset(reset), .SerialData(sdata), .CsSelect(csSel),
    .Cpol(cpol), .Cpha(cpha), .DataoutStart(start && sel == 1), .Busy(busyB),
    .DataoutDone(doneB), .SelError(selErrB), .SerialDataIn(rdB), .SCLK(sclkB),
    .SDI(sdiB), .SDO(sdo), .nCS(ncsB));

  spi_master_param #(.DATA_WIDTH(24), .NUM_CS(3), .CLK_DIV(5)) dutC (
    .Clk(Clk), .reset(reset), .SerialData(sdata), .CsSelect(csSel),
    .Cpol(cpol), .Cpha(cpha), .DataoutStart(start && sel == 2), .Busy(busyC),
    .DataoutDone(doneC), .SelError(selErrC), .SerialDataIn(rdC), .SCLK(sclkC),
    .SDI(sdiC), .SDO(sdo), .nCS(ncsC));

  logic busy, done, selErr, sclk, sdi; logic [23:0] rdata; logic [3:0] ncs;

  // Route the selected instance onto one observation bus (absent nCS bits read 1).
  always_comb begin
    busy = busyA; done = doneA; selErr = selErrA; sclk = sclkA; sdi = sdiA;
    rdata = {8'h0, rdA}; ncs = ncsA;
    if (sel == 1) begin
      busy = busyB; done = doneB; selErr = selErrB; sclk = sclkB; sdi = sdiB;
      rdata = rdB; ncs = {1'b1, ncsB};
    end else if (sel == 2) begin
      busy = busyC; done = doneC; selErr = selErrC; sclk = sclkC; sdi = sdiC;
      rdata = rdC; ncs = {1'b1, ncsC};
    end
  end

  function automatic int dwOf(input int s);  return (s == 0) ? 16 : 24; endfunction
  function automatic int divOf(input int s); return (s == 0) ? 2 : (s == 1) ? 1 : 5; endfunction

  // One transfer against a behavioural slave (or SDO looped back to SDI).
  task automatic run_xfer(input int s, input logic [23:0] data, input logic [1:0] cs,
                          input logic pol, input logic pha, input logic [23:0] slaveWord,
                          input logic loopback);
    int dw, expDone, doneAt, edges, rises, ncsBad, busyBad, sdiBad, drvIdx;
    logic [23:0] slaveRx, mask, expRx;
    logic [3:0]  expNcs;
    logic        prevSclk, prevSdi, lead;
    dw = dwOf(s);
    expDone = 1 + 1 + 2 * dw * divOf(s) + 1;
    mask = (dw == 16) ? 24'h00FFFF : 24'hFFFFFF;
    expRx = (loopback ? data : slaveWord) & mask;
    expNcs = 4'hF; expNcs[cs] = 1'b0;
    doneAt = 0; edges = 0; rises = 0; ncsBad = 0; busyBad = 0; sdiBad = 0;
    drvIdx = 0; slaveRx = '0; prevSclk = 1'b0; prevSdi = 1'b0;
    @(negedge Clk);
    sel = s; sdata = data; csSel = cs; cpol = pol; cpha = pha; sdo = 1'b0; start = 1'b1;
    for (int n = 1; n <= expDone + 20 && doneAt == 0; n++) begin
      @(negedge Clk);
      if (n == 1) begin
        start = 1'b0;
        vectors++;
        if (sclk !== pol) begin
          miscompares++;
          $display("FAIL sclk_idle_before sel=%0d got %b want %b", s, sclk, pol);
        end
        if (!pha && !loopback) begin sdo = slaveWord[dw-1]; drvIdx = 1; end
      end
      if (done) doneAt = n;
      else begin
        if (ncs !== expNcs) ncsBad++;
        if (busy !== 1'b1) busyBad++;
        if (n > 1 && sclk !== prevSclk) begin
          edges++;
          if (sclk) rises++;
          lead = edges[0];
          if (lead != pha) begin
            if (sdi !== prevSdi) sdiBad++;
            slaveRx = {slaveRx[22:0], prevSdi};
          end else if (!loopback && drvIdx < dw) begin
            sdo = slaveWord[dw-1-drvIdx];
            drvIdx++;
          end
        end
      end
      prevSclk = sclk; prevSdi = sdi;
      if (loopback) sdo = sdi;
    end
    vectors += 8;
    if (doneAt !== expDone) begin miscompares++;
      $display("FAIL done_cycle sel=%0d got %0d want %0d", s, doneAt, expDone); end
    if (rdata !== expRx) begin miscompares++;
      $display("FAIL rx_word sel=%0d got %h want %h", s, rdata, expRx); end
    if ((slaveRx & mask) !== (data & mask)) begin miscompares++;
      $display("FAIL slave_rx sel=%0d got %h want %h", s, slaveRx & mask, data & mask); end
    if (ncsBad != 0 || busyBad != 0) begin miscompares++;
      $display("FAIL ncs_busy_during sel=%0d badNcs %0d badBusy %0d want 0", s, ncsBad, busyBad); end
    if (edges != 2 * dw || rises != dw) begin miscompares++;
      $display("FAIL sclk_edges sel=%0d got %0d/%0d want %0d/%0d", s, edges, rises, 2 * dw, dw); end
    if (sdiBad != 0) begin miscompares++;
      $display("FAIL sdi_stable sel=%0d got %0d changes want 0", s, sdiBad); end
    if ({ncs, busy, sdi, sclk} !== {4'hF, 1'b0, 1'b0, pol}) begin miscompares++;
      $display("FAIL done_outputs sel=%0d got %b want %b", s, {ncs, busy, sdi, sclk},
               {4'hF, 1'b0, 1'b0, pol}); end
    @(negedge Clk);
    if ({done, sclk} !== {1'b0, pol}) begin miscompares++;
      $display("FAIL after_done sel=%0d got %b want %b", s, {done, sclk}, {1'b0, pol}); end
  endtask

  task automatic test_reset();
    sel = 0; start = 1'b0; sdata = '0; csSel = '0; cpol = 1'b0; cpha = 1'b0; sdo = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge Clk);
    reset = 1'b0;
    @(negedge Clk);
    vectors += 3;
    if ({busyA, doneA, selErrA, sdiA, sclkA, ncsA, rdA} !== {5'b00001, 4'hF, 16'h0}) begin
      miscompares++; $display("FAIL reset_a got %h", {busyA, doneA, selErrA, sdiA, sclkA, ncsA, rdA}); end
    if ({busyB, doneB, selErrB, sdiB, sclkB, ncsB, rdB} !== {5'b00001, 3'h7, 24'h0}) begin
      miscompares++; $display("FAIL reset_b got %h", {busyB, doneB, selErrB, sdiB, sclkB, ncsB, rdB}); end
    if ({busyC, doneC, selErrC, sdiC, sclkC, ncsC, rdC} !== {5'b00001, 3'h7, 24'h0}) begin
      miscompares++; $display("FAIL reset_c got %h", {busyC, doneC, selErrC, sdiC, sclkC, ncsC, rdC}); end
  endtask

  task automatic test_mode0_loopback();
    run_xfer(0, 24'h00A5C3, 2'd2, 1'b0, 1'b0, 24'h0, 1'b1);
  endtask

  task automatic test_modes();
    for (int m = 1; m < 4; m++)
      run_xfer(0, 24'($urandom), 2'($urandom_range(0, 3)), m[1], m[0], 24'h003C5A, 1'b0);
  endtask

  task automatic test_clkdiv();
    run_xfer(1, 24'($urandom), 2'd1, 1'b0, 1'b0, 24'($urandom), 1'b0);
    run_xfer(2, 24'($urandom), 2'd2, 1'b1, 1'b1, 24'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back();
    int dones, gap, gapSeen, secondAt;
    logic inGap;
    dones = 0; gap = 0; gapSeen = -1; secondAt = 0; inGap = 1'b0;
    @(negedge Clk);
    sel = 0; sdata = 24'h001234; csSel = 2'd1; cpol = 1'b0; cpha = 1'b0; sdo = 1'b0;
    start = 1'b1;
    for (int n = 1; n <= 160; n++) begin
      @(negedge Clk);
      if (done) begin dones++; inGap = 1'b1; gap = 0; end
      if (inGap && ncs === 4'hF) gap++;
      else if (inGap) begin
        inGap = 1'b0;
        if (secondAt == 0) begin gapSeen = gap; secondAt = n; end
      end
      if (secondAt > 0) start = (n == secondAt + 10 || n == secondAt + 30);
    end
    start = 1'b0;
    vectors += 3;
    if (gapSeen != 1) begin miscompares++;
      $display("FAIL b2b_gap got %0d want 1", gapSeen); end
    if (dones != 2) begin miscompares++;
      $display("FAIL b2b_dones got %0d want 2", dones); end
    if ({busy, ncs} !== {1'b0, 4'hF}) begin miscompares++;
      $display("FAIL b2b_no_queue got %b want %b", {busy, ncs}, {1'b0, 4'hF}); end
  endtask

  task automatic test_sel_error();
    logic sclkBefore;
    @(negedge Clk);
    sel = 1; csSel = 2'd3; cpol = 1'b0; sclkBefore = sclk; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    vectors += 2;
    if ({selErr, busy, ncs, sclk} !== {1'b1, 1'b0, 4'hF, sclkBefore}) begin miscompares++;
      $display("FAIL sel_error got %b want %b", {selErr, busy, ncs, sclk},
               {1'b1, 1'b0, 4'hF, sclkBefore}); end
    @(negedge Clk);
    if ({selErr, busy, ncs} !== {1'b0, 1'b0, 4'hF}) begin miscompares++;
      $display("FAIL sel_error_pulse got %b want %b", {selErr, busy, ncs}, {1'b0, 1'b0, 4'hF}); end
  endtask

  task automatic test_reset_mid();
    int spurious;
    spurious = 0;
    @(negedge Clk);
    sel = 0; sdata = 24'h00BEEF; csSel = 2'd0; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (30) @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    vectors += 2;
    if ({ncs, sclk, busy, done} !== {4'hF, 1'b1, 1'b0, 1'b0}) begin miscompares++;
      $display("FAIL reset_mid got %b want %b", {ncs, sclk, busy, done}, {4'hF, 1'b1, 1'b0, 1'b0}); end
    repeat (60) begin @(negedge Clk); if (done || busy) spurious++; end
    if (spurious != 0) begin miscompares++;
      $display("FAIL reset_mid_quiet got %0d active cycles want 0", spurious); end
    run_xfer(0, 24'h00F00D, 2'd3, 1'b0, 1'b0, 24'h0, 1'b1);
  endtask

  task automatic test_random();
    int s;
    for (int i = 0; i < 6; i++) begin
      s = $urandom_range(0, 2);
      run_xfer(s, 24'($urandom), 2'($urandom_range(0, (s == 0) ? 3 : 2)),
               1'($urandom), 1'($urandom), 24'($urandom), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_loopback();
    test_modes();
    test_clkdiv();
    test_back_to_back();
    test_sel_error();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master for the DIF slow-control path: serialises a DATA_WIDTH-bit word MSB-first on SDI while capturing SDO full-duplex. It supports all four SPI modes, a programmable SCLK divider, and NUM_CS independent chip selects. It replaces the fixed 16-bit, single-CS, write-only serialiser used for DAC/ASIC configuration. Chip-select setup and hold intervals are configurable.

## Interface
- DATA_WIDTH, 16, bits per transfer (≥2)
- NUM_CS, 4, number of chip-select lines (≥1)
- CLK_DIV, 2, Clk cycles per SCLK half-period (≥1)
- CS_SETUP, 1, Clk cycles from nCS fall to first SCLK edge (≥1)
- CS_HOLD, 1, Clk cycles from end of last SCLK half-period to nCS rise (≥1)
- RESET_CPOL, 1, SCLK idle level after reset
- Clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- SerialData  in  DATA_WIDTH  word to transmit; sampled on accepted start
- CsSelect  in  max(1,$clog2(NUM_CS))  target chip select; sampled on start
- Cpol, Cpha  in  1 each  SPI mode; sampled on start
- DataoutStart  in  1  transfer request, level-sampled in IDLE
- Busy  out  1  high from accept edge until the DataoutDone edge
- DataoutDone  out  1  one-cycle pulse at end of transfer
- SelError  out  1  one-cycle pulse: start rejected, CsSelect ≥ NUM_CS
- SerialDataIn  out  DATA_WIDTH  captured SDO word; valid from DataoutDone, held until next done
- SCLK  out  1  serial clock
- SDI  out  1  master data out
- SDO  in  1  slave data in
- nCS  out  NUM_CS  active-low selects, one-hot-low during transfer

## Operation
- Reset values: Busy=0, DataoutDone=0, SelError=0, SerialDataIn=0, SDI=0, nCS=all 1, SCLK=RESET_CPOL, latched Cpol=RESET_CPOL, Cpha=0.
- Reset mid-transfer aborts at the next edge: outputs go to reset values, no DataoutDone.
- States:
  - IDLE → SETUP on DataoutStart with valid CsSelect.
  - SETUP → SHIFT after CS_SETUP cycles.
  - SHIFT → HOLD after 2·DATA_WIDTH half-periods.
  - HOLD → DONE after CS_HOLD cycles.
  - DONE → IDLE unconditionally.
- On accept: latch SerialData, CsSelect, Cpol, Cpha; drive nCS[CsSelect]=0; Busy=1.
- DataoutStart while Busy is ignored, never queued.
- On invalid CsSelect: stay IDLE, pulse SelError; no nCS/SCLK activity.
- SCLK idles at latched Cpol. SHIFT produces 2·DATA_WIDTH edges, alternating leading/trailing, the first at SHIFT entry, spaced CLK_DIV cycles apart.
- CPHA=0: MSB driven on SDI at the accept edge. SDO sampled on each leading edge. Next bit driven on each trailing edge except the last.
- CPHA=1: each bit driven on a leading edge. SDO sampled on each trailing edge.
- Sampling means the SDO value present before the Clk edge that toggles SCLK. Samples shift into SerialDataIn's shadow register at the LSB; after DATA_WIDTH samples the first sample is the MSB.
- Bit counter width is $clog2(DATA_WIDTH+1). The divider counter wraps 0..CLK_DIV-1.
- DONE edge: nCS all 1, SDI=0, SCLK=Cpol, DataoutDone=1, Busy=0, SerialDataIn updated.
- A start sampled high in the cycle after DONE is accepted, giving exactly 1 Clk of nCS high between back-to-back transfers.

## Timing
- Start sampled at edge 0 → nCS low at edge 1.
- First SCLK edge at edge 1+CS_SETUP.
- Edge k (0-based) at 1+CS_SETUP+k·CLK_DIV.
- DataoutDone/nCS high at edge 1+CS_SETUP+2·DATA_WIDTH·CLK_DIV+CS_HOLD.
- Defaults give 67 cycles.
- SCLK period = 2·CLK_DIV·Tclk, 50% duty. CLK_DIV=1 gives Clk/2.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package spi_master_pkg: state enum (IDLE, SETUP, SHIFT, HOLD, DONE) and a mode struct {cpol, cpha}.
- Sub-module spi_clk_gen: divider counter emitting lead_edge/trail_edge strobes and the SCLK level, enabled only in SHIFT.
- Top module holds the FSM, shift registers, and nCS decode.

## Test plan
- Mode 0, defaults, SerialData=16'hA5C3, CsSelect=2, SDO looped to SDI:
  - nCS=4'b1011 for the transfer.
  - 16 rising SCLK edges.
  - DataoutDone at cycle 67 with SerialDataIn=16'hA5C3.
- Each mode 1/2/3 with slave model returning 16'h3C5A: SerialDataIn=16'h3C5A, SCLK idle=Cpol before and after, SDI stable across every sampling edge.
- CLK_DIV=1 and CLK_DIV=5, DATA_WIDTH=24: half-period=1/5 cycles; done at 1+1+48·CLK_DIV+1.
- Back-to-back starts held high: exactly 1 cycle nCS high between words; DataoutStart pulses while Busy ignored (one DataoutDone per accepted start).
- CsSelect=5 with NUM_CS=4 is only possible if the select width permits it; otherwise use NUM_CS=3, CsSelect=3: SelError pulse, Busy stays 0, nCS all high.
- reset asserted at bit 7: next edge nCS=all 1, SCLK=RESET_CPOL, Busy=0, no DataoutDone; a new transfer then completes normally.
